// File: rtl/dfe_pkg.sv
// dfe_pkg: shared ratio decode, width derivation and state encoding for the DFE blocks
package dfe_pkg;
  localparam int CIC_WIDTH = 16;
  localparam int CIC_N_STAGES = 3;
  localparam int CIC_LOG2_R_MAX = 4;
  localparam logic [4:0] R_1 = 5'd1;
  localparam logic [4:0] R_2 = 5'd2;
  localparam logic [4:0] R_4 = 5'd4;
  localparam logic [4:0] R_8 = 5'd8;
  localparam logic [4:0] R_16 = 5'd16;
  typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;
  function automatic int acc_width(input int w, input int n, input int l);
    return w + n * l;
  endfunction
  function automatic logic [2:0] ratio_log2(input logic [4:0] r);
    return r == R_2 ? 3'd1 : r == R_4 ? 3'd2 : r == R_8 ? 3'd3 : r == R_16 ? 3'd4 : 3'd0;
  endfunction
  function automatic logic [4:0] ratio_norm(input logic [4:0] r);
    return R_1 << ratio_log2(r);
  endfunction
endpackage

// File: rtl/cic_integrator_chain.sv
// cic_integrator_chain: cascaded wrapping accumulators with enable and synchronous clear
module cic_integrator_chain
  import dfe_pkg::*;
#(
  parameter int N_STAGES = CIC_N_STAGES,
  parameter int ACC_WIDTH = acc_width(CIC_WIDTH, CIC_N_STAGES, CIC_LOG2_R_MAX)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        clr,
  input  logic signed [ACC_WIDTH-1:0] din,
  output logic signed [ACC_WIDTH-1:0] sum
);
  logic signed [ACC_WIDTH-1:0] acc_q [N_STAGES];
  logic signed [ACC_WIDTH-1:0] acc_d [N_STAGES];
  logic signed [ACC_WIDTH-1:0] s;
  // each stage adds the freshly summed value of the one before, so an impulse reaches the output in the same cycle
  always_comb begin
    s = din;
    for (int k = 0; k < N_STAGES; k++) begin
      s = acc_q[k] + s;
      acc_d[k] = clr ? '0 : en ? s : acc_q[k];
    end
    sum = s;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_STAGES; k++) acc_q[k] <= '0;
    end else begin
      for (int k = 0; k < N_STAGES; k++) acc_q[k] <= acc_d[k];
    end
  end
endmodule

// File: rtl/cic_interpolator.sv
// cic_interpolator: N-stage CIC upsampler by R in {1,2,4,8,16}, scaled back to unity DC gain
module cic_interpolator
  import dfe_pkg::*;
#(
  parameter int WIDTH = CIC_WIDTH,
  parameter int N_STAGES = CIC_N_STAGES,
  parameter int LOG2_R_MAX = CIC_LOG2_R_MAX,
  parameter int ACC_WIDTH = acc_width(WIDTH, N_STAGES, LOG2_R_MAX)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4:0]              R,
  input  logic signed [WIDTH-1:0] x_input,
  input  logic                    valid_in,
  output logic                    ready_out,
  output logic signed [WIDTH-1:0] y_output,
  output logic                    valid_out
);
  state_t state_q, state_d;
  logic [4:0] r_lat_q, r_lat_d, phase_q, phase_d, r_new;
  logic signed [ACC_WIDTH-1:0] dly_q [N_STAGES];
  logic signed [ACC_WIDTH-1:0] dly_d [N_STAGES];
  logic signed [ACC_WIDTH-1:0] comb_q, comb_d, c, integ_in, integ_sum;
  logic signed [WIDTH-1:0] y_q, y_d;
  logic valid_q, valid_d, emit, last, ready, accept, clr, bypass, ld;
  logic [7:0] sh;
  always_comb begin
    r_new = ratio_norm(R);
    emit = state_q == EMIT;
    last = emit && phase_q == r_lat_q - 5'd1;
    ready = state_q == IDLE || last;
    accept = valid_in && ready;
    clr = accept && r_new != r_lat_q;
    bypass = accept && state_q == IDLE && r_new == R_1;
    ld = accept && !bypass;
    c = ACC_WIDTH'(x_input);
    for (int k = 0; k < N_STAGES; k++) begin
      dly_d[k] = ld ? c : clr ? '0 : dly_q[k];
      c = c - (clr ? '0 : dly_q[k]);
    end
    comb_d = ld ? c : comb_q;
    integ_in = phase_q == '0 ? comb_q : '0;
    sh = 8'(ratio_log2(r_lat_q) * (N_STAGES - 1));
    phase_d = emit && !last ? phase_q + 5'd1 : '0;
    state_d = state_q == LOAD ? EMIT : state_q == IDLE ? (ld ? LOAD : IDLE) : (last && !accept ? IDLE : EMIT);
    r_lat_d = accept ? r_new : r_lat_q;
    // a ratio change wipes the integrators, so that edge produces no output sample
    y_d = bypass ? x_input : emit && !clr ? WIDTH'(integ_sum >>> sh) : y_q;
    valid_d = bypass || (emit && !clr);
  end
  cic_integrator_chain #(.N_STAGES(N_STAGES), .ACC_WIDTH(ACC_WIDTH)) u_int (
    .clk(clk),
    .rst(rst),
    .en(emit),
    .clr(clr),
    .din(integ_in),
    .sum(integ_sum)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      r_lat_q <= '0;
      phase_q <= '0;
      comb_q <= '0;
      y_q <= '0;
      valid_q <= 1'b0;
      for (int k = 0; k < N_STAGES; k++) dly_q[k] <= '0;
    end else begin
      state_q <= state_d;
      r_lat_q <= r_lat_d;
      phase_q <= phase_d;
      comb_q <= comb_d;
      y_q <= y_d;
      valid_q <= valid_d;
      for (int k = 0; k < N_STAGES; k++) dly_q[k] <= dly_d[k];
    end
  end
  assign ready_out = ready && !rst;
  assign y_output = y_q;
  assign valid_out = valid_q;
endmodule

// File: tb/tb_cic_interpolator.sv
// tb_cic_interpolator: directed vectors and burst sequences for the CIC interpolator
module tb_cic_interpolator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid_in = 1'b0;
  logic [4:0] R = 5'd1;
  logic signed [15:0] x_input = '0;
  logic ready_out, valid_out;
  logic signed [15:0] y_output;
  int n_chk = 0;
  int n_fail = 0;
  int ys[$];
  int n_val, first_v, last_v, na;
  int dc_early[6] = '{62, 187, 375, 625, 812, 937};
  typedef struct {
    logic [4:0] r;
    int x;
    logic vin;
    logic rdy;
    logic vo;
    int y;
  } vec_t;
  vec_t tbl [18];

  always #5 clk = ~clk;

  cic_interpolator dut (
    .clk(clk),
    .rst(rst),
    .R(R),
    .x_input(x_input),
    .valid_in(valid_in),
    .ready_out(ready_out),
    .y_output(y_output),
    .valid_out(valid_out)
  );

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input int i);
    R = tbl[i].r;
    x_input = 16'(tbl[i].x);
    valid_in = tbl[i].vin;
    #1 chk($sformatf("vec%0d ready", i), ready_out, tbl[i].rdy);
    @(posedge clk);
    #1 chk($sformatf("vec%0d valid", i), valid_out, tbl[i].vo);
    if (tbl[i].vo) chk($sformatf("vec%0d y", i), y_output, tbl[i].y);
  endtask

  // xv is presented whenever the bench expects ready_out, junk otherwise
  task automatic stream(input logic [4:0] r, input int rr, input int n_in, input int xv, input int junk, output int n_acc);
    n_acc = 0;
    n_val = 0;
    first_v = -1;
    last_v = -1;
    ys.delete();
    for (int cy = 0; cy < n_in + rr + 8; cy++) begin
      logic er;
      er = cy == 0 || (cy > rr && (cy - rr - 1) % rr == 0);
      R = r;
      valid_in = cy < n_in;
      x_input = 16'(er ? xv : junk);
      #1 if (cy < n_in) chk($sformatf("R%0d ready c%0d", rr, cy), ready_out, er);
      if (cy < n_in && er) n_acc++;
      @(posedge clk);
      #1 if (valid_out) begin
        ys.push_back(y_output);
        n_val++;
        if (first_v < 0) first_v = cy;
        last_v = cy;
      end
    end
    valid_in = 1'b0;
    chk($sformatf("R%0d first out", rr), first_v, 2);
    chk($sformatf("R%0d out count", rr), n_val, rr * n_acc);
    chk($sformatf("R%0d gapless", rr), last_v - first_v + 1, n_val);
  endtask

  initial begin
    tbl[0]  = '{5'd1, 5, 1'b1, 1'b1, 1'b1, 5};
    tbl[1]  = '{5'd1, -7, 1'b1, 1'b1, 1'b1, -7};
    tbl[2]  = '{5'd1, 32767, 1'b1, 1'b1, 1'b1, 32767};
    tbl[3]  = '{5'd1, 0, 1'b0, 1'b1, 1'b0, 0};
    tbl[4]  = '{5'd3, 100, 1'b1, 1'b1, 1'b1, 100};
    tbl[5]  = '{5'd3, -32768, 1'b1, 1'b1, 1'b1, -32768};
    tbl[6]  = '{5'd3, 0, 1'b0, 1'b1, 1'b0, 0};
    tbl[7]  = '{5'd2, 4096, 1'b1, 1'b1, 1'b0, 0};
    tbl[8]  = '{5'd2, 0, 1'b1, 1'b0, 1'b0, 0};
    tbl[9]  = '{5'd2, 0, 1'b1, 1'b0, 1'b1, 1024};
    tbl[10] = '{5'd2, 0, 1'b1, 1'b1, 1'b1, 3072};
    tbl[11] = '{5'd2, 0, 1'b1, 1'b0, 1'b1, 3072};
    tbl[12] = '{5'd2, 0, 1'b1, 1'b1, 1'b1, 1024};
    tbl[13] = '{5'd2, 0, 1'b1, 1'b0, 1'b1, 0};
    tbl[14] = '{5'd2, 0, 1'b1, 1'b1, 1'b1, 0};
    tbl[15] = '{5'd2, 0, 1'b1, 1'b0, 1'b1, 0};
    tbl[16] = '{5'd2, 0, 1'b0, 1'b1, 1'b1, 0};
    tbl[17] = '{5'd2, 0, 1'b0, 1'b1, 1'b0, 0};

    #2;
    chk("reset y", y_output, 0);
    chk("reset valid", valid_out, 0);
    chk("reset ready", ready_out, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("post-reset ready", ready_out, 1);
    @(posedge clk);
    #1 chk("post-reset valid", valid_out, 0);

    for (int i = 0; i < 18; i++) run_vec(i);

    stream(5'd4, 4, 26, 1000, 1000, na);
    for (int j = 0; j < ys.size(); j++) chk($sformatf("dc y%0d", j), ys[j], j < 6 ? dc_early[j] : 1000);

    stream(5'd8, 8, 50, 800, -32768, na);
    for (int j = 0; j < ys.size(); j++)
      if (j == 0 || j >= 24) chk($sformatf("bp y%0d", j), ys[j], j == 0 ? 12 : 800);

    stream(5'd16, 16, 1, 5000, 0, na);
    chk("r16 y0", ys[0], 19);
    chk("r16 y15", ys[15], 2656);
    for (int i = 7; i < 18; i++) run_vec(i);

    R = 5'd8;
    x_input = 16'sd3000;
    valid_in = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("pre-reset valid", valid_out, 1);
    chk("pre-reset y", y_output, 281);
    #2 rst = 1'b1;
    #1 chk("mid reset y", y_output, 0);
    chk("mid reset valid", valid_out, 0);
    chk("mid reset ready", ready_out, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("after mid reset ready", ready_out, 1);
    @(posedge clk);
    #1 chk("after mid reset valid", valid_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cic_interpolator.md
Name: cic_interpolator

Overview:
- Transmit-direction counterpart of the receive chain's decimate-then-compensate path: a multi-stage CIC interpolator that upsamples a 16-bit stream by a runtime ratio R ∈ {1,2,4,8,16}.
- Combs run at the input rate, zero-stuffing inserts R-1 zeros per sample, integrators run at the output rate.
- The output is scaled back to unity DC gain.
- Sits between the TX baseband source and the DAC-side datapath; one output sample per clock while a burst is emitting.

Parameters:
- WIDTH, 16, input/output sample width (signed).
- N_STAGES, 3, number of comb stages and number of integrator stages.
- LOG2_R_MAX, 4, log2 of the largest ratio (16).
- ACC_WIDTH, WIDTH + N_STAGES*LOG2_R_MAX (28), internal comb/integrator width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- R  in  5  interpolation ratio; 1, 2, 4, 8 or 16; any other value is treated as 1
- x_input  in  WIDTH  signed input sample
- valid_in  in  1  input sample valid
- ready_out  out  1  block can accept x_input this cycle
- y_output  out  WIDTH  signed interpolated sample
- valid_out  out  1  y_output valid this cycle

Behaviour:
- Reset (async, rst=1): all comb delays, integrators, phase counter and the latched ratio go to 0; state = IDLE; y_output=0, valid_out=0, ready_out=0 while rst=1.
- Accept: a sample is accepted when valid_in && ready_out on a rising clk edge.
  - R is latched (r_lat) at each accept and held for the whole burst.
  - If the new R differs from r_lat, all comb and integrator state is cleared in the same edge before the new sample enters.
- States:
  - IDLE: ready_out=1. Accept → LOAD.
  - LOAD: one cycle; comb chain output registered (comb_q); phase=0. → EMIT.
  - EMIT: phase counts 0..r_lat-1, one step per cycle. Integrator input = comb_q when phase==0, else 0.
    - ready_out=1 only when phase==r_lat-1.
    - An accept at that edge → LOAD-merged: comb_q updates and phase wraps to 0, staying in EMIT (gapless stream at input rate clk/R).
    - No accept at phase==r_lat-1 → IDLE.
- Latency: accept at edge t → comb_q valid after edge t+1 → first y_output/valid_out after edge t+2. R outputs follow on consecutive cycles.
- Combs: N_STAGES differential delay of 1, in ACC_WIDTH. Updated only on accept.
- Integrators: N_STAGES cascade in ACC_WIDTH. Updated every EMIT cycle; hold otherwise. Two's-complement wrap is required (no saturation inside).
- Output scaling: y_output = integrator_last >>> ((N_STAGES-1)*log2(r_lat)), truncated to WIDTH. The result is bounded by the input magnitude, so no saturation logic is needed.
- valid_out is registered: 1 in the cycle after each EMIT update, 0 otherwise.
- Bypass (r_lat==1): no LOAD/EMIT; ready_out=1 continuously; y_output <= x_input and valid_out <= 1 one cycle after accept; valid_out=0 after a cycle with no accept.
- Reset mid-burst: immediate return to reset values; the partial burst is discarded.
- valid_in while ready_out=0: ignored. The source must hold the sample; no data loss is guaranteed only under that rule.

Decomposition:
- Shared package dfe_pkg holds:
  - the ratio encoding constants (R_1..R_16) and a ratio→log2 function with invalid→0;
  - N_STAGES and ACC_WIDTH derivations;
  - the state enum (IDLE, LOAD, EMIT).
- One sub-module cic_integrator_chain: N_STAGES integrators with enable and synchronous clear, ACC_WIDTH wide. Combs, control FSM and scaling stay in the top.

Test Plan:
- Reset: assert rst mid-operation → y_output=0, valid_out=0, ready_out=0 immediately. After deassert: ready_out=1, no valid_out.
- Bypass: R=1, stream 5, -7, 32767 on consecutive cycles → identical samples on y_output one cycle later, valid_out high 3 cycles, ready_out never low. R=3 behaves identically.
- Impulse: R=2, single input 4096 then zeros at full rate → y_output 1024, 3072, 3072, 1024, then 0s. First output two cycles after accept.
- DC step: R=4, constant 1000 streamed gaplessly → output settles to exactly 1000 within 3 input samples. valid_out continuously high, ready_out high 1 cycle in 4.
- Backpressure: R=8, valid_in held high with changing data → only samples presented when ready_out=1 are consumed. Exactly 8 valid_out per accepted sample.
- R change: run R=16 burst, go IDLE, switch to R=2 with input 4096 → state flushed; output equals the clean R=2 impulse response (1024, 3072, 3072, 1024).
